// File: rtl/freq_meter_if.sv
// Handshake bundle for freq_meter: measurement control/input and published result.
interface freq_meter_if #(
  parameter int unsigned WIDTH = 27
);
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] freq;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output enable, sig_in,
    input  freq, valid, overflow, busy
  );

  modport slave (
    input  enable, sig_in,
    output freq, valid, overflow, busy
  );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed gate window of clk cycles
// and publishes the (saturating) count with a one-cycle valid strobe.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  freq_meter_if.slave bus
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GW-1:0]          gate_q, gate_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [WIDTH-1:0]       freq_q, freq_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   sig_edge;
  logic [WIDTH-1:0]       cnt_inc;
  logic                   sat_inc;

  // Synchronizer and edge detector run in every state so the first gate cycle sees edges.
  assign sig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      gate_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      prev_q  <= sync_q[SYNC_STAGES-1];
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and window bookkeeping; the terminal cycle's own edge is folded into the result.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    cnt_inc = cnt_q;
    sat_inc = 1'b0;

    if (sig_edge) begin
      if (cnt_q == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = cnt_q + WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        sat_d  = 1'b0;
        if (bus.enable) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (gate_q == GATE_LAST) begin
          freq_d  = cnt_inc;
          ovf_d   = sat_q | sat_inc;
          valid_d = 1'b1;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = bus.enable ? GATE : IDLE;
        end else if (!bus.enable) begin
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = IDLE;
        end else begin
          gate_d = gate_q + GW'(1);
          cnt_d  = cnt_inc;
          sat_d  = sat_q | sat_inc;
        end
      end
    endcase

    busy_d = (state_d == GATE);
  end

  assign bus.freq     = freq_q;
  assign bus.overflow = ovf_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule
